// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: turns the ps2_key toggle-strobe bus into queued key events (FWFT FIFO).
// Optional PS2_KEY_FIFO_TIMESTAMP_EN adds a 16-bit tick-based timestamp per entry.
`default_nettype none

module ps2_key_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [10:0]           ps2_key,
    input  logic                  rd,
    input  logic                  clr_ovf,
    output logic [9:0]            dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
`ifdef PS2_KEY_FIFO_TIMESTAMP_EN
    ,
    input  logic                  ce_tick,
    output logic [15:0]           ts_out
`endif
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [9:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  strobe_q;
    logic                  armed;

    logic key_event;
    logic pop_ok;
    logic push_ok;
    logic drop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign key_event = armed && (ps2_key[10] != strobe_q);
    assign pop_ok    = rd && !empty;
    // A pop in the same cycle frees a slot, so a full queue can still accept the push.
    assign push_ok   = key_event && (!full || pop_ok);
    assign drop      = key_event && !push_ok;

    assign dout = empty ? 10'd0 : mem[rd_ptr];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
            armed    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            strobe_q <= ps2_key[10];
            armed    <= 1'b1;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: dout is masked while empty and writes require armed.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= ps2_key[9:0];
        end
    end

`ifdef PS2_KEY_FIFO_TIMESTAMP_EN
    logic [15:0] ts_mem [DEPTH];
    logic [15:0] tick_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= 16'd0;
        end else if (ce_tick) begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            ts_mem[wr_ptr] <= tick_cnt;
        end
    end

    assign ts_out = empty ? 16'd0 : ts_mem[rd_ptr];
`endif

endmodule

`default_nettype wire
